// File: rtl/magia_axi_stdio_tap.sv
// AXI4 write-path tap: forwards tile traffic to L2 unchanged while extracting
// stdout characters, the stderr code and the end-of-computation exit code.

package magia_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } axi_ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } axi_w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_chan_t;

  typedef struct packed {
    axi_ax_chan_t aw;
    logic         aw_valid;
    axi_w_chan_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_ax_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_default_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    logic        b_valid;
    axi_b_chan_t b;
    logic        r_valid;
    axi_r_chan_t r;
  } axi_default_rsp_t;
endpackage

module magia_axi_stdio_tap #(
  parameter int unsigned          AddrWidth  = 32,
  parameter int unsigned          DataWidth  = 32,
  parameter logic [AddrWidth-1:0] StderrAddr = 32'hFFFF_0000,
  parameter logic [AddrWidth-1:0] StdoutAddr = 32'hFFFF_0004,
  parameter logic [AddrWidth-1:0] EocAddr    = 32'hCC03_0000,
  parameter int unsigned          AwDepth    = 4,
  parameter int unsigned          CharDepth  = 16,
  parameter type                  axi_req_t  = magia_pkg::axi_default_req_t,
  parameter type                  axi_rsp_t  = magia_pkg::axi_default_rsp_t
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  axi_req_t    slv_req_i,
  output axi_rsp_t    slv_rsp_o,
  output axi_req_t    mst_req_o,
  input  axi_rsp_t    mst_rsp_i,
  output logic [7:0]  char_o,
  output logic        char_valid_o,
  input  logic        char_ready_i,
  output logic [31:0] err_code_o,
  output logic        err_valid_o,
  output logic [31:0] exit_code_o,
  output logic        eoc_o,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned LaneWidth = (StrbWidth > 1) ? $clog2(StrbWidth) : 1;
  localparam int unsigned AwIdxW    = $clog2(AwDepth);
  localparam int unsigned CharIdxW  = $clog2(CharDepth);
  localparam logic [AddrWidth-1:0] LaneMask = AddrWidth'(StrbWidth - 1);

  typedef enum logic [1:0] {KindNone, KindStdout, KindStderr, KindEoc} kind_e;

  typedef struct packed {
    kind_e                kind;
    logic [LaneWidth-1:0] lane;
  } aw_entry_t;

  // Write-tracking FIFO: one entry per accepted AW, popped on W.last.
  aw_entry_t         aw_mem_q [AwDepth];
  logic [AwIdxW-1:0] aw_wr_idx_q, aw_wr_idx_d, aw_rd_idx_q, aw_rd_idx_d;
  logic              aw_wr_wrap_q, aw_wr_wrap_d, aw_rd_wrap_q, aw_rd_wrap_d;
  logic              aw_full, aw_empty, aw_push, aw_pop;
  logic              aw_fwd_valid, w_fwd_valid, w_hs;
  aw_entry_t         aw_new, aw_head;
  logic [AddrWidth-1:0] aw_word;

  logic [7:0]        char_mem_q [CharDepth];
  logic [CharIdxW:0] char_wr_q, char_wr_d, char_rd_q, char_rd_d;
  logic              char_full, char_empty, char_pop, char_req, char_push;

  logic [31:0] err_code_q, err_code_d, exit_code_q, exit_code_d;
  logic        err_valid_q, err_valid_d, eoc_q, eoc_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [7:0]  w_byte;
  logic        w_strb_bit;
  logic [31:0] w_word;

  assign aw_full  = (aw_wr_idx_q == aw_rd_idx_q) && (aw_wr_wrap_q != aw_rd_wrap_q);
  assign aw_empty = (aw_wr_idx_q == aw_rd_idx_q) && (aw_wr_wrap_q == aw_rd_wrap_q);

  assign aw_fwd_valid = slv_req_i.aw_valid & ~aw_full;
  assign w_fwd_valid  = slv_req_i.w_valid & ~aw_empty;
  assign aw_push      = aw_fwd_valid & mst_rsp_i.aw_ready;
  assign w_hs         = w_fwd_valid & mst_rsp_i.w_ready;
  assign aw_pop       = w_hs & slv_req_i.w.last;

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = aw_fwd_valid;
    mst_req_o.w_valid  = w_fwd_valid;
    slv_rsp_o          = mst_rsp_i;
    slv_rsp_o.aw_ready = mst_rsp_i.aw_ready & ~aw_full;
    slv_rsp_o.w_ready  = mst_rsp_i.w_ready & ~aw_empty;
  end

  assign aw_word = slv_req_i.aw.addr & ~LaneMask;

  always_comb begin
    aw_new.kind = KindNone;
    aw_new.lane = LaneWidth'(slv_req_i.aw.addr & LaneMask);
    if (aw_word == (StdoutAddr & ~LaneMask))      aw_new.kind = KindStdout;
    else if (aw_word == (StderrAddr & ~LaneMask)) aw_new.kind = KindStderr;
    else if (aw_word == (EocAddr & ~LaneMask))    aw_new.kind = KindEoc;
  end

  // Depth need not be a power of two, so indices wrap explicitly and toggle the wrap bit.
  always_comb begin
    aw_wr_idx_d  = aw_wr_idx_q;
    aw_wr_wrap_d = aw_wr_wrap_q;
    aw_rd_idx_d  = aw_rd_idx_q;
    aw_rd_wrap_d = aw_rd_wrap_q;
    if (aw_push) begin
      if (aw_wr_idx_q == AwIdxW'(AwDepth - 1)) begin
        aw_wr_idx_d  = '0;
        aw_wr_wrap_d = ~aw_wr_wrap_q;
      end else begin
        aw_wr_idx_d = aw_wr_idx_q + AwIdxW'(1);
      end
    end
    if (aw_pop) begin
      if (aw_rd_idx_q == AwIdxW'(AwDepth - 1)) begin
        aw_rd_idx_d  = '0;
        aw_rd_wrap_d = ~aw_rd_wrap_q;
      end else begin
        aw_rd_idx_d = aw_rd_idx_q + AwIdxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (aw_push) aw_mem_q[aw_wr_idx_q] <= aw_new;
  end

  assign aw_head    = aw_mem_q[aw_rd_idx_q];
  assign w_byte     = slv_req_i.w.data[{aw_head.lane, 3'b000} +: 8];
  assign w_strb_bit = slv_req_i.w.strb[aw_head.lane];
  assign w_word     = slv_req_i.w.data[31:0];

  assign char_empty = (char_wr_q == char_rd_q);
  assign char_full  = (char_wr_q[CharIdxW] != char_rd_q[CharIdxW]) &&
                      (char_wr_q[CharIdxW-1:0] == char_rd_q[CharIdxW-1:0]);
  assign char_pop   = ~char_empty & char_ready_i;
  assign char_req   = w_hs & (aw_head.kind == KindStdout) & w_strb_bit & (w_byte != 8'h00);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign char_push  = char_req & (~char_full | char_pop);

  always_comb begin
    char_wr_d   = char_wr_q;
    char_rd_d   = char_rd_q;
    drop_cnt_d  = drop_cnt_q;
    err_code_d  = err_code_q;
    err_valid_d = err_valid_q;
    exit_code_d = exit_code_q;
    eoc_d       = eoc_q;
    if (char_push) char_wr_d = char_wr_q + (CharIdxW + 1)'(1);
    if (char_pop)  char_rd_d = char_rd_q + (CharIdxW + 1)'(1);
    if (char_req && !char_push && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    if (w_hs && aw_head.kind == KindStderr) begin
      err_code_d  = w_word;
      err_valid_d = 1'b1;
    end
    if (w_hs && aw_head.kind == KindEoc && !eoc_q) begin
      exit_code_d = w_word;
      eoc_d       = (w_word != 32'h0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (char_push) char_mem_q[char_wr_q[CharIdxW-1:0]] <= w_byte;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      aw_wr_idx_q  <= '0;
      aw_wr_wrap_q <= 1'b0;
      aw_rd_idx_q  <= '0;
      aw_rd_wrap_q <= 1'b0;
      char_wr_q    <= '0;
      char_rd_q    <= '0;
      drop_cnt_q   <= '0;
      err_code_q   <= '0;
      err_valid_q  <= 1'b0;
      exit_code_q  <= '0;
      eoc_q        <= 1'b0;
    end else begin
      aw_wr_idx_q  <= aw_wr_idx_d;
      aw_wr_wrap_q <= aw_wr_wrap_d;
      aw_rd_idx_q  <= aw_rd_idx_d;
      aw_rd_wrap_q <= aw_rd_wrap_d;
      char_wr_q    <= char_wr_d;
      char_rd_q    <= char_rd_d;
      drop_cnt_q   <= drop_cnt_d;
      err_code_q   <= err_code_d;
      err_valid_q  <= err_valid_d;
      exit_code_q  <= exit_code_d;
      eoc_q        <= eoc_d;
    end
  end

  assign char_valid_o = ~char_empty;
  assign char_o       = char_empty ? 8'h00 : char_mem_q[char_rd_q[CharIdxW-1:0]];
  assign err_code_o   = err_code_q;
  assign err_valid_o  = err_valid_q;
  assign exit_code_o  = exit_code_q;
  assign eoc_o        = eoc_q;
  assign drop_cnt_o   = drop_cnt_q;

endmodule
